// File: rtl/jtag_reg_access_if.sv
// Bundles the command, response, core write-port snoop and register file JTAG
// port signals used by jtag_reg_access.
interface jtag_reg_access_if;
    // command channel
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [4:0]  cmd_addr_i;
    logic [31:0] cmd_data_i;
    // response channel
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [1:0]  rsp_status_o;
    // core mem_wb write port, observed for collisions
    logic        core_w_enable_i;
    logic [4:0]  core_w_addr_i;
    // register file JTAG port
    logic        jtag_w_enable_o;
    logic [4:0]  jtag_addr_o;
    logic [31:0] jtag_w_data_o;
    logic [31:0] jtag_r_data_i;

    // controller side
    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_data_o, rsp_status_o,
        input  rsp_ready_i,
        input  core_w_enable_i, core_w_addr_i,
        output jtag_w_enable_o, jtag_addr_o, jtag_w_data_o,
        input  jtag_r_data_i
    );

    // debug transport / environment side
    modport master (
        output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_data_o, rsp_status_o,
        output rsp_ready_i,
        output core_w_enable_i, core_w_addr_i,
        input  jtag_w_enable_o, jtag_addr_o, jtag_w_data_o,
        output jtag_r_data_i
    );
endinterface

// File: rtl/jtag_reg_access.sv
// JTAG-side register file access controller: one command at a time, retries
// accesses that collide with the core's mem_wb write port, returns one
// response per command.
module jtag_reg_access #(
    parameter int RETRY_MAX = 15
) (
    input logic               clk,
    input logic               rst_n,
    jtag_reg_access_if.slave  bus
);
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_BADOP   = 2'b11;

    localparam logic [7:0] LP_CNT_LAST = 8'(RETRY_MAX - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t      r_state,    w_state_nx;
    logic [4:0]  r_addr,     w_addr_nx;
    logic [31:0] r_data,     w_data_nx;
    logic [7:0]  r_cnt,      w_cnt_nx;
    logic [31:0] r_rsp_data, w_rsp_data_nx;
    logic [1:0]  r_rsp_stat, w_rsp_stat_nx;

    // The register file drops a JTAG write whenever mem_wb writes any
    // non-zero register, so any such cycle costs the write a retry.
    logic w_wr_coll;
    // A read is only stale if the core is updating the same register.
    logic w_rd_stale;
    logic w_cnt_last;

    assign w_wr_coll  = bus.core_w_enable_i && (bus.core_w_addr_i != 5'd0);
    assign w_rd_stale = bus.core_w_enable_i && (bus.core_w_addr_i == r_addr) &&
                        (r_addr != 5'd0);
    assign w_cnt_last = (r_cnt == LP_CNT_LAST);

    // Outputs come straight from registered state; rst_n gates ready so it
    // stays low while reset is held.
    assign bus.cmd_ready_o     = (r_state == S_IDLE) && rst_n;
    assign bus.rsp_valid_o     = (r_state == S_RESP);
    assign bus.rsp_data_o      = r_rsp_data;
    assign bus.rsp_status_o    = r_rsp_stat;
    assign bus.jtag_w_enable_o = (r_state == S_WRITE);
    assign bus.jtag_addr_o     = r_addr;
    assign bus.jtag_w_data_o   = r_data;

    // State and command/response latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= 5'd0;
            r_data     <= 32'd0;
            r_cnt      <= 8'd0;
            r_rsp_data <= 32'd0;
            r_rsp_stat <= 2'b00;
        end else begin
            r_state    <= w_state_nx;
            r_addr     <= w_addr_nx;
            r_data     <= w_data_nx;
            r_cnt      <= w_cnt_nx;
            r_rsp_data <= w_rsp_data_nx;
            r_rsp_stat <= w_rsp_stat_nx;
        end
    end

    // Next-state decode: accept, access with retry, respond.
    always_comb begin
        w_state_nx    = r_state;
        w_addr_nx     = r_addr;
        w_data_nx     = r_data;
        w_cnt_nx      = r_cnt;
        w_rsp_data_nx = r_rsp_data;
        w_rsp_stat_nx = r_rsp_stat;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    w_addr_nx     = bus.cmd_addr_i;
                    w_data_nx     = bus.cmd_data_i;
                    w_cnt_nx      = 8'd0;
                    w_rsp_data_nx = 32'd0;
                    w_rsp_stat_nx = ST_OK;
                    case (bus.cmd_op_i)
                        OP_READ:  w_state_nx = S_READ;
                        // x0 is hardwired, so a write to it completes at once
                        OP_WRITE: w_state_nx = (bus.cmd_addr_i != 5'd0) ? S_WRITE : S_RESP;
                        OP_NOP:   w_state_nx = S_RESP;
                        default: begin
                            w_state_nx    = S_RESP;
                            w_rsp_stat_nx = ST_BADOP;
                        end
                    endcase
                end
            end
            S_READ: begin
                if (w_rd_stale) begin
                    if (w_cnt_last) begin
                        w_state_nx    = S_RESP;
                        w_rsp_stat_nx = ST_TIMEOUT;
                        w_rsp_data_nx = 32'd0;
                    end else begin
                        w_cnt_nx = r_cnt + 8'd1;
                    end
                end else begin
                    w_state_nx    = S_RESP;
                    w_rsp_stat_nx = ST_OK;
                    w_rsp_data_nx = bus.jtag_r_data_i;
                end
            end
            S_WRITE: begin
                if (w_wr_coll) begin
                    if (w_cnt_last) begin
                        w_state_nx    = S_RESP;
                        w_rsp_stat_nx = ST_TIMEOUT;
                    end else begin
                        w_cnt_nx = r_cnt + 8'd1;
                    end
                end else begin
                    w_state_nx    = S_RESP;
                    w_rsp_stat_nx = ST_OK;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready_i) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end
endmodule

// File: doc/jtag_reg_access.md
# jtag_reg_access

Debug-side controller that drives the register file's JTAG port (`jtag_w_enable`, `jtag_addr`, `jtag_w_data`, `jtag_r_data`) on behalf of the JTAG debug transport. It accepts one read or write command at a time over a valid/ready handshake and performs the register access. It retries writes that lose arbitration to the core's mem_wb write port. It returns a single response with data and status over a second valid/ready handshake.

## Interface
- `RETRY_MAX`, default 15: collision cycles tolerated before a command fails with timeout; legal range 1..255.
- `clk` input, 1 bit: core clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `cmd_valid_i` input, 1 bit: command present.
- `cmd_ready_o` output, 1 bit: block can accept a command.
- `cmd_op_i` input, 2 bits: 00 nop, 01 read, 10 write, 11 reserved.
- `cmd_addr_i` input, 5 bits: target register index.
- `cmd_data_i` input, 32 bits: write data.
- `rsp_valid_o` output, 1 bit: response present.
- `rsp_ready_i` input, 1 bit: response consumed.
- `rsp_data_o` output, 32 bits: read data; 0 for non-read or failed commands.
- `rsp_status_o` output, 2 bits: 00 ok, 10 timeout, 11 bad op.
- `core_w_enable_i` input, 1 bit: mem_wb write enable into the register file.
- `core_w_addr_i` input, 5 bits: mem_wb write address.
- `jtag_w_enable_o` output, 1 bit: to register file JTAG write enable.
- `jtag_addr_o` output, 5 bits: to register file JTAG address.
- `jtag_w_data_o` output, 32 bits: to register file JTAG write data.
- `jtag_r_data_i` input, 32 bits: from register file JTAG read data (combinational, no bypass; 0 for x0).

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - `cmd_ready_o`=1.
  - On `cmd_valid_i`&`cmd_ready_o`, latch op/addr/data, clear retry counter (8 bits).
  - op 01 -> READ.
  - op 10 with addr≠0 -> WRITE.
  - op 10 with addr=0 -> RESP, status 00.
  - op 00 -> RESP, status 00, data 0.
  - op 11 -> RESP, status 11, data 0.
- Collision: `core_w_enable_i`=1 and `core_w_addr_i`≠0. The register file gives mem_wb priority and drops the JTAG write in any such cycle, regardless of address.
- WRITE:
  - `jtag_w_enable_o`=1; `jtag_addr_o`/`jtag_w_data_o` = latched values.
  - No collision this cycle: write commits at the clock edge -> RESP, status 00.
  - Collision: counter+1 and stay in WRITE.
  - Collision with counter = RETRY_MAX-1: -> RESP, status 10, no commit.
- READ:
  - `jtag_addr_o` = latched addr; `jtag_r_data_i` is captured at the end of the cycle.
  - If `core_w_enable_i`=1 and `core_w_addr_i` = latched addr (≠0), the capture is stale: counter+1 and stay in READ.
  - Same-address collision with counter = RETRY_MAX-1: -> RESP, status 10, data 0.
  - Otherwise -> RESP, status 00, data = captured value.
  - Core writes to other addresses do not disturb READ.
- RESP:
  - `rsp_valid_o`=1; data/status stable until `rsp_valid_o`&`rsp_ready_i`.
  - On handshake -> IDLE.
- `jtag_w_enable_o` is asserted only in WRITE.
- `jtag_addr_o`/`jtag_w_data_o` hold the last latched values in all other states.

## Timing
- Reset (asynchronous, any state): state IDLE.
  - All outputs 0 except `cmd_ready_o`, which is 1 once `rst_n` deasserts.
  - Latched command, counter, and response registers cleared.
  - Any in-flight command is discarded without a response.
- All outputs are decoded from registered state or latches; no combinational path from `cmd_*`/`rsp_ready_i` to outputs.
- Uncontended latency, command accepted at edge N:
  - Access cycle N+1.
  - `rsp_valid_o` high from cycle N+2.
  - `cmd_ready_o` high again the cycle after the response handshake.
- Nop, x0-write, and reserved commands: `rsp_valid_o` high at N+1.
- Each collision cycle adds one cycle; worst case before a timeout response is RETRY_MAX access cycles.
- `cmd_ready_o` is 0 in READ/WRITE/RESP; commands presented then are held off, not dropped.
- Back-to-back commands: minimum spacing is one IDLE cycle between response handshake and next accept.

## Test plan
- Write x5=0xDEADBEEF, no core activity -> `jtag_w_enable_o` high exactly 1 cycle, `rsp_valid_o` at N+2, status 00; a following read of x5 returns 0xDEADBEEF.
- Write x7 with `core_w_enable_i`=1, `core_w_addr_i`=3 for 4 cycles -> WRITE lasts 5 cycles, commit on the 5th, status 00, x3 keeps its core value.
- RETRY_MAX=15, write x9 with continuous core writes to x1 -> status 10 after 15 WRITE cycles, x9 unchanged, data 0.
- Read x2 after reset -> data = sp_init, status 00. Read x4 while the core writes x4 for 2 cycles -> 3 READ cycles, returns the core's new value. Read x0 -> 0.
- Write x0, op 11, op 00 -> response at N+1; statuses 00/11/00, data 0, `jtag_w_enable_o` never high.
- Hold `rsp_ready_i`=0 for 10 cycles -> response stable, `cmd_ready_o`=0. Assert `rst_n`=0 mid-WRITE -> all outputs 0 immediately, no response after release.
